// File: rtl/seg7_pattern_rx.sv
// Receive-side 7-segment decoder: synchronise, debounce and decode a segment bus to BCD.
// Optional sequence checking of the 0..9..0 count is enabled by defining SEGRX_SEQ_CHECK_EN.
module seg7_pattern_rx #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_in,
  output logic [3:0]  digit,
  output logic        digit_valid,
  output logic        new_digit,
  output logic        pat_err,
  output logic        seq_err,
  output logic [15:0] accept_cnt
);

  // state    | meaning
  // S_EMPTY  | no pattern accepted since reset
  // S_FILTER | r_cand under test, r_stab_cnt counts matching cycles
  // S_LOCKED | r_cand accepted, waiting for the next change
  typedef enum logic [1:0] {S_EMPTY, S_FILTER, S_LOCKED} state_t;

  localparam logic [6:0]  BLANK    = 7'h7F;
  localparam logic [15:0] LAST_CNT = 16'(STABLE_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [6:0]  w_norm, r_sync1, r_sync2, r_cand;
  logic [15:0] r_stab_cnt;
  logic        w_change, w_accept, w_new;
  logic        w_dec_legal, w_dec_blank;
  logic [3:0]  w_dec_digit;

  // Patterns are kept in active-low notation (0 = segment lit) from here on.
  assign w_norm = ACTIVE_LOW ? seg_in : ~seg_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= BLANK;
      r_sync2 <= BLANK;
    end else begin
      r_sync1 <= w_norm;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_change)
      w_state_nxt = S_FILTER;
    else if (r_state == S_FILTER && r_stab_cnt == LAST_CNT)
      w_state_nxt = S_LOCKED;
  end

  always_comb begin
    w_change = (r_sync2 != r_cand);
    w_accept = (r_state == S_FILTER) && !w_change && (r_stab_cnt == LAST_CNT);
  end

  always_comb begin
    w_dec_legal = 1'b1;
    w_dec_blank = 1'b0;
    w_dec_digit = 4'd0;
    case (r_cand)
      7'b1000000: w_dec_digit = 4'd0;
      7'b1111001: w_dec_digit = 4'd1;
      7'b0100100: w_dec_digit = 4'd2;
      7'b0110000: w_dec_digit = 4'd3;
      7'b0011001: w_dec_digit = 4'd4;
      7'b0010010: w_dec_digit = 4'd5;
      7'b0000010: w_dec_digit = 4'd6;
      7'b1011000,
      7'b1111000: w_dec_digit = 4'd7;
      7'b0000000: w_dec_digit = 4'd8;
      7'b0010000: w_dec_digit = 4'd9;
      BLANK: begin
        w_dec_legal = 1'b0;
        w_dec_blank = 1'b1;
      end
      default:    w_dec_legal = 1'b0;
    endcase
  end

  // A digit only counts as new if it differs from the digit currently shown.
  assign w_new = w_accept && w_dec_legal && !(digit_valid && (w_dec_digit == digit));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand     <= BLANK;
      r_stab_cnt <= '0;
    end else if (w_change) begin
      r_cand     <= r_sync2;
      r_stab_cnt <= '0;
    end else if (r_state == S_FILTER && !w_accept) begin
      r_stab_cnt <= r_stab_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit       <= 4'd0;
      digit_valid <= 1'b0;
      new_digit   <= 1'b0;
      pat_err     <= 1'b0;
      accept_cnt  <= '0;
    end else begin
      new_digit <= w_new;
      pat_err   <= w_accept && !w_dec_legal && !w_dec_blank;
      if (w_new) accept_cnt <= accept_cnt + 16'd1;
      if (w_accept) begin
        if (w_dec_legal) begin
          digit       <= w_dec_digit;
          digit_valid <= 1'b1;
        end else begin
          digit_valid <= 1'b0;
        end
      end
    end
  end

`ifdef SEGRX_SEQ_CHECK_EN
  logic [3:0] w_succ;
  logic       w_seq;

  // digit_valid still describes the previous accept at this point.
  assign w_succ = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
  assign w_seq  = w_new && digit_valid && (w_dec_digit != w_succ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seq_err <= 1'b0;
    else        seq_err <= w_seq;
  end
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_pattern_rx.sv
// Scoreboard bench for seg7_pattern_rx: directed scenarios plus randomized pattern holds.
module tb_seg7_pattern_rx;
  localparam int S = 4;
`ifdef SEGRX_SEQ_CHECK_EN
  localparam bit SEQ = 1'b1;
`else
  localparam bit SEQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_in = 7'h7F;
  logic [3:0]  digit;
  logic        digit_valid, new_digit, pat_err, seq_err;
  logic [15:0] accept_cnt;

  seg7_pattern_rx #(.STABLE_CYCLES(S), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .digit(digit),
    .digit_valid(digit_valid), .new_digit(new_digit), .pat_err(pat_err),
    .seq_err(seq_err), .accept_cnt(accept_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit is_pat;
    int d;
    bit seq;
    int cnt;
    int cyc;
  } ev_t;
  ev_t q[$];

  bit         m_valid;
  int         m_digit, m_cnt;
  logic [6:0] prev_drv = 7'h7F;
  logic [6:0] enc[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                          7'b0010010, 7'b0000010, 7'b1011000, 7'b0000000, 7'b0010000};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // 0..9 digit, 10 blank, 11 illegal
  function automatic int classify(input logic [6:0] p);
    case (p)
      7'b1000000: return 0;
      7'b1111001: return 1;
      7'b0100100: return 2;
      7'b0110000: return 3;
      7'b0011001: return 4;
      7'b0010010: return 5;
      7'b0000010: return 6;
      7'b1011000, 7'b1111000: return 7;
      7'b0000000: return 8;
      7'b0010000: return 9;
      7'b1111111: return 10;
      default:    return 11;
    endcase
  endfunction

  // Pattern placed on the bus right after edge k is accepted at edge k+S+3.
  task automatic model_accept(input logic [6:0] p, input int k);
    int c;
    ev_t e;
    c = classify(p);
    if (c < 10) begin
      if (!(m_valid && m_digit == c)) begin
        m_cnt = (m_cnt + 1) & 16'hFFFF;
        e = '{0, c, SEQ && m_valid && (c != (m_digit + 1) % 10), m_cnt, k + S + 3};
        q.push_back(e);
      end
      m_valid = 1'b1;
      m_digit = c;
    end else if (c == 10) begin
      m_valid = 1'b0;
    end else begin
      e = '{1, m_digit, 0, m_cnt, k + S + 3};
      q.push_back(e);
      m_valid = 1'b0;
    end
  endtask

  // Called just after a rising edge; leaves again just after a rising edge.
  task automatic hold(input logic [6:0] p, input int dur);
    seg_in = p;
    if (p != prev_drv && dur >= S + 1) model_accept(p, cyc);
    prev_drv = p;
    repeat (dur) @(posedge clk);
    #1;
    if (dur >= S + 3) begin
      chk("level_digit_valid", int'(digit_valid), int'(m_valid));
      chk("level_digit", int'(digit), m_digit);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() != 0 && cyc > q[0].cyc) begin
        chk("missed_pulse_cycle", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (new_digit || pat_err) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", int'({new_digit, pat_err}), 0);
        end else begin
          ev_t e;
          e = q.pop_front();
          chk("pulse_cycle", cyc, e.cyc);
          chk("pat_err", int'(pat_err), int'(e.is_pat));
          chk("new_digit", int'(new_digit), int'(!e.is_pat));
          chk("digit", int'(digit), e.d);
          chk("digit_valid", int'(digit_valid), int'(!e.is_pat));
          chk("seq_err", int'(seq_err), int'(e.seq));
          chk("accept_cnt", int'(accept_cnt), e.cnt);
        end
      end else if (seq_err) begin
        chk("seq_err_without_new_digit", int'(seq_err), 0);
      end
    end
  end

  initial begin
    logic [6:0] p;
    int d, dur;
    m_valid = 1'b0; m_digit = 0; m_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_digit", int'(digit), 0);
    chk("rst_digit_valid", int'(digit_valid), 0);
    chk("rst_new_digit", int'(new_digit), 0);
    chk("rst_pat_err", int'(pat_err), 0);
    chk("rst_seq_err", int'(seq_err), 0);
    chk("rst_accept_cnt", int'(accept_cnt), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    hold(7'b1111001, 20);
    hold(7'b0100100, 3);
    hold(7'b1111001, 20);

    hold(7'h7F, 20);
    for (int i = 0; i <= 10; i++) hold(enc[i % 10], 20);

    hold(enc[3], 20);
    hold(enc[5], 20);

    hold(7'b0101010, 20);
    hold(7'h7F, 20);
    hold(enc[2], 20);
    chk("queue_drained_before_reset", q.size(), 0);

    // Reset two cycles into a filter window
    seg_in = enc[6];
    prev_drv = enc[6];
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_digit", int'(digit), 0);
    chk("midrst_digit_valid", int'(digit_valid), 0);
    chk("midrst_new_digit", int'(new_digit), 0);
    chk("midrst_pat_err", int'(pat_err), 0);
    chk("midrst_seq_err", int'(seq_err), 0);
    chk("midrst_accept_cnt", int'(accept_cnt), 0);
    m_valid = 1'b0; m_digit = 0; m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_accept(enc[6], cyc);
    repeat (S + 2) @(posedge clk);
    #1;
    chk("post_rst_not_early", int'(digit_valid), 0);
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_digit_valid", int'(digit_valid), 1);
    chk("post_rst_digit", int'(digit), 6);

    for (int i = 0; i < 300; i++) begin
      do begin
        case ($urandom_range(0, 9))
          6:       p = 7'h7F;
          7:       p = 7'($urandom_range(0, 127));
          default: begin
            d = $urandom_range(0, 9);
            p = (d == 7 && $urandom_range(0, 1) == 1) ? 7'b1111000 : enc[d];
          end
        endcase
      end while (p == prev_drv);
      dur = $urandom_range(1, 10);
      hold(p, dur);
    end
    if (prev_drv == 7'h7F) hold(enc[8], 20);
    hold(7'h7F, 20);
    chk("queue_drained_at_end", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_pattern_rx.md
# seg7_pattern_rx

Receive-side decoder for the 7-segment LED bus driven by the board's segment counters. Samples a raw 7-bit segment pattern, synchronises and debounces it, and decodes it back to a BCD digit. Flags illegal patterns and, optionally, breaks in the 0→9→0 counting sequence. Sits on the monitor/self-check path next to the segment driver, or on an input header for an external display.

## Interface
Parameters:
- STABLE_CYCLES, 16: synchronised pattern must be unchanged for this many clocks before acceptance; legal range 1..65535.
- ACTIVE_LOW, 1: 1 = common-anode bus, segment lit when bit is 0; 0 = lit when bit is 1.

Ports:
- clk  input  1  system clock (100 MHz board clock).
- rst_n  input  1  asynchronous, active-low reset.
- seg_in  input  7  raw segment bus, bit0=a … bit6=g; asynchronous to clk.
- digit  output  4  last accepted digit, 0..9.
- digit_valid  output  1  level; digit reflects a legal pattern currently displayed.
- new_digit  output  1  one-cycle pulse when a newly accepted pattern is a digit differing from the last accepted pattern.
- pat_err  output  1  one-cycle pulse when a stable illegal pattern is accepted.
- seq_err  output  1  one-cycle pulse, sequence break (see Configuration).
- accept_cnt  output  16  count of new_digit pulses, wraps 0xFFFF→0.

## Operation
- Polarity normalised first: lit = ACTIVE_LOW ? ~seg_in : seg_in. All decoding below uses active-low notation (g..a).
- Two-flop synchroniser; both flops reset to the blank value (all segments unlit).
- Legal patterns (g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1011000 and 1111000 (both accepted), 8=0000000, 9=0010000. Blank=1111111. Anything else is illegal.
- FSM states:
  - EMPTY (reset): no accepted pattern yet.
  - FILTER: candidate register cand holds the pattern under test; stab_cnt counts matching cycles.
  - LOCKED: cand accepted.
- Transitions:
  - Any state: synchronised value ≠ cand → load cand, clear stab_cnt, go to FILTER.
  - FILTER with match: stab_cnt increments.
  - FILTER, match and stab_cnt = STABLE_CYCLES-1 → accept, go to LOCKED.
  - LOCKED with match: stays, no pulses.
- On accept:
  - Legal digit ≠ last accepted pattern: digit updated, digit_valid=1, new_digit pulse, accept_cnt+1.
  - Legal digit equal to last accepted pattern (glitch returned): no pulse, outputs unchanged.
  - Blank: digit_valid=0, digit holds, no pulse, no error.
  - Illegal: digit_valid=0, digit holds, pat_err pulse.
- Both 7 encodings decode to 7. Switching between them counts as the same digit: no pulse.

## Timing
- Reset values: digit=0, digit_valid=0, new_digit=0, pat_err=0, seq_err=0, accept_cnt=0, state=EMPTY, cand=blank.
- Latency: seg_in changes before edge N and then holds. Accept occurs at edge N+STABLE_CYCLES+2. Outputs are registered; pulses are high for exactly the cycle after that edge.
- A change shorter than the filter window is never accepted. The window restarts from 0 on each change.
- new_digit, seq_err and accept_cnt update on the same edge.
- Reset asserted mid-filter or mid-pulse: all outputs clear immediately (asynchronous). After release, behaviour is as from power-up. The first accept needs a full window.

## Configuration
- SEGRX_SEQ_CHECK_EN defined: seq_err pulses with new_digit when both hold:
  - the previous accept was a legal digit p;
  - the new digit ≠ (p+1) mod 10.
- 9→0 is legal. The first digit after reset, blank or illegal is not checked.
- Undefined: seq_err is a constant 0 and the sequence logic is absent.

## Test plan
- STABLE_CYCLES=4: reset, drive 1111001 → at edge N+6, digit=1, digit_valid=1, new_digit for one cycle, accept_cnt=1.
- Drive 0100100 for 3 cycles, then return to 1111001 → no new_digit, digit stays 1.
- Walk 0..9..0 at 0.5 s-style spacing (shortened to 20 cycles), including 7 as 1011000 → 11 new_digit pulses, seq_err never asserts; SEGRX_SEQ_CHECK_EN build.
- Jump 3→5 → new_digit and seq_err in the same cycle in the SEGRX_SEQ_CHECK_EN build; seq_err=0 in the default build.
- Hold 0101010 → one pat_err pulse, digit_valid=0, digit unchanged. Then blank 1111111 → no pulse. Then 2 → new_digit, no seq_err.
- Assert rst_n=0 two cycles into a filter window → all outputs 0 immediately. After release, a held digit is accepted only after a full N+6 window.
